// File: rtl/mult_seq_pkg.sv
// Shared types for the repeated-addition multiplier controller:
// state encoding, decoder one-hot constants and the state-to-strobe decode.
package mult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        ADD    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

    localparam logic [2:0] HSEL_NONE = 3'b000;
    localparam logic [2:0] HSEL_A    = 3'b001;
    localparam logic [2:0] HSEL_B    = 3'b010;
    localparam logic [2:0] HSEL_P    = 3'b100;

    typedef struct packed {
        logic       ld_a;
        logic       ld_b;
        logic       ld_p;
        logic       clr_p;
        logic       dec_b;
        logic       mux_sel;
        logic [2:0] hsel;
        logic       busy;
        logic       done;
    } strobe_t;

    // Moore decode; unused encodings behave like IDLE (everything low).
    function automatic strobe_t decode_state(input state_e st);
        strobe_t s;
        s = strobe_t'(11'd0);
        case (st)
            IDLE: begin
                s = strobe_t'(11'd0);
            end
            LOAD_A: begin
                s.ld_a  = 1'b1;
                s.clr_p = 1'b1;
                s.hsel  = HSEL_A;
                s.busy  = 1'b1;
            end
            LOAD_B: begin
                s.ld_b = 1'b1;
                s.hsel = HSEL_B;
                s.busy = 1'b1;
            end
            CHECK: begin
                s.busy = 1'b1;
            end
            ADD: begin
                s.ld_p    = 1'b1;
                s.dec_b   = 1'b1;
                s.mux_sel = 1'b1;
                s.hsel    = HSEL_P;
                s.busy    = 1'b1;
            end
            DONE, ERR: begin
                s.done = 1'b1;
                s.busy = 1'b1;
            end
            default: begin
                s = strobe_t'(11'd0);
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mult_seq_controller_if.sv
// Handshake and datapath-strobe bundle between the multiplier controller
// (master) and the PIPO/MUX/decoder datapath plus requester (slave).
interface mult_seq_controller_if;
    logic       start;
    logic       eqz;
    logic       ld_a;
    logic       ld_b;
    logic       ld_p;
    logic       clr_p;
    logic       dec_b;
    logic       mux_sel;
    logic [2:0] hsel;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, eqz,
        output ld_a, ld_b, ld_p, clr_p, dec_b, mux_sel, hsel, busy, done, err
    );

    modport slave (
        output start, eqz,
        input  ld_a, ld_b, ld_p, clr_p, dec_b, mux_sel, hsel, busy, done, err
    );
endinterface

// File: rtl/mult_seq_controller.sv
// Control FSM sequencing load A, load B, then add-and-decrement until B == 0,
// with a start/done handshake and a sticky abort after MAX_ITER additions.
module mult_seq_controller
    import mult_seq_pkg::*;
#(
    parameter int                 CNT_W    = 16,
    parameter logic [CNT_W-1:0]   MAX_ITER = {CNT_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_seq_controller_if.master bus
);

    state_e            state_r;
    state_e            next_state_s;
    logic [CNT_W-1:0]  iter_cnt_r;
    strobe_t           strobe_r;
    logic              err_r;

    // Next-state selection; start and eqz only influence the registered state.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = LOAD_A;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD_A: next_state_s = LOAD_B;
            LOAD_B: next_state_s = CHECK;
            CHECK: begin
                if (bus.eqz) begin
                    next_state_s = DONE;
                end else if (iter_cnt_r == MAX_ITER) begin
                    next_state_s = ERR;
                end else begin
                    next_state_s = ADD;
                end
            end
            ADD:     next_state_s = CHECK;
            DONE:    next_state_s = IDLE;
            ERR:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register plus strobes pre-decoded from the next state, so the
    // outputs are flops that always match the decode of state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            strobe_r <= strobe_t'(11'd0);
        end else begin
            state_r  <= next_state_s;
            strobe_r <= decode_state(next_state_s);
        end
    end

    // Sticky abort flag: raised on entry to ERR, cleared on entry to LOAD_A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (next_state_s == LOAD_A) begin
            err_r <= 1'b0;
        end else if (next_state_s == ERR) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Iteration counter; CHECK diverts to ERR at MAX_ITER, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == LOAD_A) begin
            iter_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ADD) begin
            iter_cnt_r <= iter_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            iter_cnt_r <= iter_cnt_r;
        end
    end

    assign bus.ld_a    = strobe_r.ld_a;
    assign bus.ld_b    = strobe_r.ld_b;
    assign bus.ld_p    = strobe_r.ld_p;
    assign bus.clr_p   = strobe_r.clr_p;
    assign bus.dec_b   = strobe_r.dec_b;
    assign bus.mux_sel = strobe_r.mux_sel;
    assign bus.hsel    = strobe_r.hsel;
    assign bus.busy    = strobe_r.busy;
    assign bus.done    = strobe_r.done;
    assign bus.err     = err_r;

endmodule

// File: tb/tb_mult_seq_controller.sv
// Bench for mult_seq_controller: two instances (full and MAX_ITER=4) driven in
// lockstep through a behavioural datapath, results checked against A*B rules.
module tb_mult_seq_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic [15:0] a0 = 16'd0, b0 = 16'd0, p0 = 16'd0;
    logic [15:0] a1 = 16'd0, b1 = 16'd0, p1 = 16'd0;
    logic        pd0 = 1'b0, pd1 = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mult_seq_controller_if m0();
    mult_seq_controller_if m1();

    mult_seq_controller #(.CNT_W(16), .MAX_ITER(16'hFFFF)) dut0 (.clk(clk), .rst(rst), .bus(m0.master));
    mult_seq_controller #(.CNT_W(16), .MAX_ITER(16'd4))    dut1 (.clk(clk), .rst(rst), .bus(m1.master));

    assign m0.start = start;
    assign m1.start = start;
    assign m0.eqz   = (b0 == 16'd0);
    assign m1.eqz   = (b1 == 16'd0);

    // Behavioural datapath for each instance: PIPO A/B, product register, adder.
    always @(posedge clk) begin
        if (m0.ld_a && !m0.mux_sel) a0 <= op_a;
        if (m0.ld_b && !m0.mux_sel) b0 <= op_b;
        if (m0.dec_b) b0 <= b0 - 16'd1;
        if (m0.clr_p) p0 <= 16'd0;
        else if (m0.ld_p && m0.mux_sel) p0 <= p0 + a0;
        if (m1.ld_a && !m1.mux_sel) a1 <= op_a;
        if (m1.ld_b && !m1.mux_sel) b1 <= op_b;
        if (m1.dec_b) b1 <= b1 - 16'd1;
        if (m1.clr_p) p1 <= 16'd0;
        else if (m1.ld_p && m1.mux_sel) p1 <= p1 + a1;
    end

    function automatic logic [11:0] outs0();
        return {m0.ld_a, m0.ld_b, m0.ld_p, m0.clr_p, m0.dec_b, m0.mux_sel,
                m0.hsel, m0.busy, m0.done, m0.err};
    endfunction

    function automatic logic [11:0] outs1();
        return {m1.ld_a, m1.ld_b, m1.ld_p, m1.clr_p, m1.dec_b, m1.mux_sel,
                m1.hsel, m1.busy, m1.done, m1.err};
    endfunction

    // Per-cycle invariants on both instances.
    always @(negedge clk) begin
        if (!rst) begin
            n_chk = n_chk + 1;
            if ($onehot0(m0.hsel) && $onehot0(m1.hsel)) n_pass = n_pass + 1;
            else $display("FAIL hsel_onehot: hsel0=%b hsel1=%b required one-hot or zero", m0.hsel, m1.hsel);
            n_chk = n_chk + 1;
            if (!(pd0 && m0.done) && !(pd1 && m1.done)) n_pass = n_pass + 1;
            else $display("FAIL done_width: done high two cycles in a row (done0=%b done1=%b)", m0.done, m1.done);
            n_chk = n_chk + 1;
            if ((({m0.ld_a, m0.ld_b, m0.ld_p, m0.done} == 4'd0) || m0.busy) &&
                (({m1.ld_a, m1.ld_b, m1.ld_p, m1.done} == 4'd0) || m1.busy)) n_pass = n_pass + 1;
            else $display("FAIL busy_cover: strobe active with busy0=%b busy1=%b, required 1", m0.busy, m1.busy);
        end
        pd0 <= m0.done;
        pd1 <= m1.done;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk = n_chk + 1;
        if (outs0() === 12'd0 && outs1() === 12'd0) n_pass = n_pass + 1;
        else $display("FAIL reset_outs: outs0=%h outs1=%h required 000", outs0(), outs1());
        rst = 1'b0;
        @(negedge clk);
        n_chk = n_chk + 1;
        if (outs0() === 12'd0 && outs1() === 12'd0) n_pass = n_pass + 1;
        else $display("FAIL idle_outs: outs0=%h outs1=%h required 000", outs0(), outs1());
    endtask

    // One job on both instances; expectations from P = A*B and the iteration cap.
    task automatic run_job(input logic [15:0] a, input logic [15:0] b);
        int          d0, d1, nld;
        logic        e0, e1, clr_ok;
        logic [15:0] rp0, exp_p;
        int          eff1;
        d0 = 0; d1 = 0; nld = 0; e0 = 1'b0; e1 = 1'b0; rp0 = 16'd0; clr_ok = 1'b1;
        exp_p = a * b;
        eff1 = (b > 16'd4) ? 4 : int'(b);
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 300 && (d0 == 0 || d1 == 0); k++) begin
            @(negedge clk);
            if (k == 1) clr_ok = (m0.err === 1'b0) && (m1.err === 1'b0);
            if (m0.ld_p) nld++;
            if (m0.done && d0 == 0) begin d0 = k; e0 = m0.err; rp0 = p0; end
            if (m1.done && d1 == 0) begin d1 = k; e1 = m1.err; end
        end
        n_chk = n_chk + 1;
        if (clr_ok) n_pass = n_pass + 1;
        else $display("FAIL err_clear: err not 0 in LOAD_A for A=%0d B=%0d", a, b);
        n_chk = n_chk + 1;
        if (d0 == 2 * int'(b) + 4) n_pass = n_pass + 1;
        else $display("FAIL done_cycle0: B=%0d got cycle %0d required %0d", b, d0, 2 * int'(b) + 4);
        n_chk = n_chk + 1;
        if (rp0 === exp_p && e0 === 1'b0) n_pass = n_pass + 1;
        else $display("FAIL product0: A=%0d B=%0d got P=%0d err=%b required P=%0d err=0", a, b, rp0, e0, exp_p);
        n_chk = n_chk + 1;
        if (nld == int'(b)) n_pass = n_pass + 1;
        else $display("FAIL add_count0: B=%0d got %0d ld_p cycles required %0d", b, nld, b);
        n_chk = n_chk + 1;
        if (d1 == 2 * eff1 + 4 && e1 === (b > 16'd4)) n_pass = n_pass + 1;
        else $display("FAIL capped1: B=%0d got cycle %0d err=%b required cycle %0d err=%b", b, d1, e1, 2 * eff1 + 4, b > 16'd4);
        repeat (3) @(negedge clk);
        n_chk = n_chk + 1;
        if (m0.busy === 1'b0 && m1.busy === 1'b0 && m1.err === (b > 16'd4)) n_pass = n_pass + 1;
        else $display("FAIL after_job: busy0=%b busy1=%b err1=%b required 0 0 %b", m0.busy, m1.busy, m1.err, b > 16'd4);
    endtask

    task automatic test_mid_reset();
        int nld;
        logic hit;
        nld = 0; hit = 1'b0;
        @(negedge clk);
        op_a = 16'd9; op_b = 16'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40 && !hit; k++) begin
            @(negedge clk);
            if (m0.ld_p) nld++;
            if (nld == 3) hit = 1'b1;
        end
        n_chk = n_chk + 1;
        if (hit) n_pass = n_pass + 1;
        else $display("FAIL reach_add3: third ADD not seen, got %0d ld_p cycles required 3", nld);
        #1 rst = 1'b1;
        #1;
        n_chk = n_chk + 1;
        if (outs0() === 12'd0 && outs1() === 12'd0) n_pass = n_pass + 1;
        else $display("FAIL async_reset: outs0=%h outs1=%h required 000", outs0(), outs1());
        @(negedge clk);
        rst = 1'b0;
        run_job(16'd9, 16'd6);
    endtask

    task automatic test_back_to_back();
        int   dq[$];
        logic idle_gap, reload;
        logic [15:0] pj[$];
        idle_gap = 1'b0; reload = 1'b0;
        @(negedge clk);
        op_a = 16'd11; op_b = 16'd2; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60 && dq.size() < 2; k++) begin
            @(negedge clk);
            if (k == 9)  idle_gap = (m0.busy === 1'b0) && (m1.busy === 1'b0);
            if (k == 10) reload = (m0.ld_a === 1'b1) && (m1.ld_a === 1'b1);
            if (m0.done) begin
                dq.push_back(k);
                pj.push_back(p0);
                op_b = 16'd3;
                if (dq.size() == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        n_chk = n_chk + 1;
        if (dq.size() == 2 && dq[0] == 8 && dq[1] == 19) n_pass = n_pass + 1;
        else $display("FAIL b2b_done: got %0d done pulses (first %0d) required cycles 8 and 19", dq.size(), (dq.size() > 0) ? dq[0] : 0);
        n_chk = n_chk + 1;
        if (idle_gap && reload) n_pass = n_pass + 1;
        else $display("FAIL b2b_gap: idle=%b reload=%b required 1 1", idle_gap, reload);
        n_chk = n_chk + 1;
        if (pj.size() == 2 && pj[0] === 16'd22 && pj[1] === 16'd33) n_pass = n_pass + 1;
        else $display("FAIL b2b_product: got %0d results (first %0d) required 22 then 33", pj.size(), (pj.size() > 0) ? pj[0] : 16'd0);
        repeat (3) @(negedge clk);
        n_chk = n_chk + 1;
        if (m0.busy === 1'b0) n_pass = n_pass + 1;
        else $display("FAIL b2b_stop: busy0=%b required 0", m0.busy);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(1, 255));
            b = 16'($urandom_range(0, 12));
            run_job(a, b);
        end
    endtask

    initial begin
        test_reset();
        run_job(16'd5, 16'd6);
        run_job(16'd7, 16'd0);
        run_job(16'd3, 16'd10);
        test_mid_reset();
        test_back_to_back();
        test_random();
        run_job(16'd1, 16'd4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
